serial_adder: RTL and testbench

- Bit-serial adder built around the existing full_adder cell. Adds two WIDTH-bit operands LSB-first, one bit per clock, using a registered carry.
- Sits downstream of operand-producing logic and wraps the combinational full_adder in a start/busy/done handshake.
- Gives an area-minimal alternative to a WIDTH-bit ripple chain for multi-cycle datapaths.

---
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// around a single full_adder cell with a registered carry and start/busy/done handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fa_s, fa_co;

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so the LSB-first result lands aligned after WIDTH shifts.
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        if (cnt_q == LAST) begin
          sum_d   = res_d;
          cout_d  = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a timing/arithmetic model predicts acceptance,
// busy/done per cycle and the held result; a monitor compares on the falling edge.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  int total = 0;
  int bad   = 0;

  logic [W:0] sb_q[$];

  // Model state: edge index, acceptance edge, earliest next accept, held result.
  int         cyc      = 0;
  int         acc_edge = -1000;
  int         free_at  = 0;
  logic [W:0] held     = '0;
  logic [W:0] pend     = '0;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  bit         chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    int unsigned s;
    s = int'(x) + int'(y) + int'(c);
    return s[W:0];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        acc_edge = -1000;
        free_at  = cyc + 1;
        held     = '0;
        sb_q.delete();
        chk_en   = 1'b1;
      end else begin
        if (cyc == acc_edge + W) held = pend;
        if (start && cyc >= free_at) begin
          pend = model_add(a, b, cin);
          sb_q.push_back(pend);
          acc_edge = cyc;
          free_at  = cyc + W + 2;
        end
      end
      exp_busy = (cyc >= acc_edge) && (cyc < acc_edge + W);
      exp_done = (cyc == acc_edge + W);
      cyc++;
    end
  end

  initial begin
    logic [W:0] exp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, exp_busy});
        chk("done", {{W{1'b0}}, done}, {{W{1'b0}}, exp_done});
        chk("held_result", {cout, sum}, held);
        if (done === 1'b1) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_without_op: got result %h expected no done at t=%0t",
                     {cout, sum}, $time);
          end else begin
            exp = sb_q.pop_front();
            chk("sb_result", {cout, sum}, exp);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 1000000", $time);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(W + 1);
  endtask

  initial begin
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("reset_result", {cout, sum}, '0);
    chk("reset_busy", {{W{1'b0}}, busy}, '0);
    step(20);

    issue(8'h35, 8'h4A, 1'b0);
    chk("add_35_4a", {cout, sum}, 9'h07F);
    step(3);
    chk("add_35_4a_hold", {cout, sum}, 9'h07F);

    issue(8'hFF, 8'h01, 1'b0);
    chk("wrap_ff_01", {cout, sum}, 9'h100);
    issue(8'hFF, 8'hFF, 1'b1);
    chk("wrap_ff_ff_c", {cout, sum}, 9'h1FF);

    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    a = 8'h11; b = 8'h22; start = 1'b1;
    step(1);
    start = 1'b0; a = 8'h77; cin = 1'b1;
    step(W - 2);
    chk("ignore_mid_start", {cout, sum}, 9'h030);

    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    step(40);
    start = 1'b0;
    step(W + 2);
    chk("continuous", {cout, sum}, 9'h003);

    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort_busy", {{W{1'b0}}, busy}, '0);
    chk("abort_result", {cout, sum}, '0);
    step(W + 2);
    issue(8'h0F, 8'hF0, 1'b1);
    chk("after_abort", {cout, sum}, 9'h100);

    rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34;
    step(1);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", {{W{1'b0}}, busy}, '0);
    step(3);

    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom_range(0, 1));
      start = 1'b1;
      step(1);
      for (int j = 0; j < W + 1 + int'($urandom_range(0, 2)); j++) begin
        start = ($urandom_range(0, 7) == 0);
        if (start) begin
          a = W'($urandom);
          b = W'($urandom);
          cin = 1'($urandom_range(0, 1));
        end
        step(1);
      end
      start = 1'b0;
    end
    step(W + 4);
    chk("scoreboard_empty", (W + 1)'(sb_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
